// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one imem request at a time, holds the fetched word
// for the decoder and handles redirects, misaligned PCs and access faults.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [1:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends combinationally on ready, and payload is held while valid waits.

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic        started;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;
    logic        inst_err_q;
    logic        load_out;
    logic [31:0] load_inst;
    logic        load_err;
    logic        misaligned;
    logic        req_fire;

    assign misaligned     = (pc[1:0] != 2'b00);
    // started keeps the request low while reset is asserted and until the first edge after release.
    assign imem_req_valid = (state == S_REQ) && started && !misaligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (state == S_HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;
    assign fsm_state      = state;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_out  = 1'b0;
        load_inst = 32'h0;
        load_err  = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = req_fire ? S_DRAIN : S_REQ;
                end else if (started && misaligned) begin
                    load_out  = 1'b1;
                    load_err  = 1'b1;
                    state_nxt = S_HOLD;
                end else if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    load_out  = 1'b1;
                    load_inst = imem_rsp_err ? 32'h0 : imem_rsp_data;
                    load_err  = imem_rsp_err;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect wins over the sequential step even when the decoder consumes.
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + 64'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            started    <= 1'b0;
            inst_q     <= 32'h0;
            inst_pc_q  <= 64'h0;
            inst_err_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            started <= 1'b1;
            if (load_out) begin
                inst_q     <= load_inst;
                inst_pc_q  <= pc;
                inst_err_q <= load_err;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios, then randomized traffic checked against
// an architectural fetch-stream model (next PC = PC+4 on consume, or redirect target).
module tb_inst_fetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clock;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fsm_state      (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
    endtask

    task automatic respond(input logic [31:0] d, input logic e);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        imem_rsp_err   = e;
    endtask

    task automatic check_hold(input string tag, input logic [31:0] d, input logic [63:0] p, input logic e);
        chk({tag, "_valid"}, inst_valid, 1'b1);
        chk({tag, "_inst"}, inst, d);
        chk({tag, "_pc"}, inst_pc, p);
        chk({tag, "_err"}, inst_err, e);
    endtask

    // Memory contents and fault map used by the randomized phase.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_0013;
    endfunction

    function automatic logic mem_fault(input logic [63:0] a);
        return a[6:2] == 5'd7;
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        if (a[1:0] != 2'b00 || mem_fault(a)) return 32'h0;
        return mem_word(a);
    endfunction

    function automatic logic exp_fault(input logic [63:0] a);
        return (a[1:0] != 2'b00) || mem_fault(a);
    endfunction

    logic [63:0] exp_pc;
    logic        mem_busy;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          idle_cnt;
    int          deliveries;
    logic        prev_stall;
    logic        fire;
    logic [63:0] tgt;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);

        chk("reset_req_valid", imem_req_valid, 1'b0);
        chk("reset_inst_valid", inst_valid, 1'b0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 64'h0);
        chk("reset_inst_err", inst_err, 1'b0);
        chk("reset_addr", imem_req_addr, RESET_PC);
        chk("reset_state", fsm_state, 2'd0);

        rst_n = 1'b1;
        chk("release_req_low", imem_req_valid, 1'b0);
        cycle();
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);

        // Basic fetch: one-cycle response, immediate consume.
        imem_req_ready = 1'b1;
        cycle();
        chk("wait_req_low", imem_req_valid, 1'b0);
        chk("wait_inst_low", inst_valid, 1'b0);
        imem_req_ready = 1'b0;
        respond(32'h0000_0413, 1'b0);
        cycle();
        check_hold("basic", 32'h0000_0413, 64'h8000_0000, 1'b0);
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("basic_next_req", imem_req_valid, 1'b1);
        chk("basic_next_addr", imem_req_addr, 64'h8000_0004);
        chk("basic_inst_drop", inst_valid, 1'b0);

        // Decoder stall for 5 cycles.
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        respond(32'h0010_0093, 1'b0);
        cycle();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_hold("stall", 32'h0010_0093, 64'h8000_0004, 1'b0);
            chk("stall_no_req", imem_req_valid, 1'b0);
            cycle();
        end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("stall_next_addr", imem_req_addr, 64'h8000_0008);
        chk("stall_next_req", imem_req_valid, 1'b1);

        // Access fault response.
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        respond(32'hdead_beef, 1'b1);
        cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        check_hold("fault", 32'h0, 64'h8000_0008, 1'b1);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("fault_next_addr", imem_req_addr, 64'h8000_000C);

        // Redirect while waiting; stale response arrives three cycles later.
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        cycle();
        redirect_valid = 1'b0;
        chk("drain_req_low", imem_req_valid, 1'b0);
        chk("drain_addr", imem_req_addr, 64'h8000_0100);
        cycle();
        chk("drain_still_low", imem_req_valid, 1'b0);
        cycle();
        chk("drain_inst_low", inst_valid, 1'b0);
        respond(32'h1111_1111, 1'b0);
        cycle();
        imem_rsp_valid = 1'b0;
        chk("stale_dropped", inst_valid, 1'b0);
        chk("redir_req_valid", imem_req_valid, 1'b1);
        chk("redir_req_addr", imem_req_addr, 64'h8000_0100);
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        respond(32'h2222_2222, 1'b0);
        cycle();
        imem_rsp_valid = 1'b0;
        check_hold("redir", 32'h2222_2222, 64'h8000_0100, 1'b0);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("redir_single", inst_valid, 1'b0);
        chk("redir_next_addr", imem_req_addr, 64'h8000_0104);

        // Redirect and consume in the same HOLD cycle.
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        respond(32'h3333_3333, 1'b0);
        cycle();
        imem_rsp_valid = 1'b0;
        check_hold("both", 32'h3333_3333, 64'h8000_0104, 1'b0);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0040;
        cycle();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("both_addr", imem_req_addr, 64'h8000_0040);
        chk("both_req", imem_req_valid, 1'b1);
        chk("both_inst_low", inst_valid, 1'b0);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0202;
        cycle();
        redirect_valid = 1'b0;
        chk("misal_no_req", imem_req_valid, 1'b0);
        cycle();
        check_hold("misal", 32'h0, 64'h8000_0202, 1'b1);
        chk("misal_no_req2", imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        cycle();
        redirect_valid = 1'b0;
        chk("misal_drop", inst_valid, 1'b0);
        chk("misal_recover", imem_req_addr, 64'h8000_1000);

        // Response with nothing outstanding is ignored.
        respond(32'h4444_4444, 1'b0);
        cycle();
        imem_rsp_valid = 1'b0;
        chk("spurious_inst", inst_valid, 1'b0);
        chk("spurious_req", imem_req_valid, 1'b1);

        // Reset in the middle of a transaction.
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", imem_req_valid, 1'b0);
        chk("midrst_inst", inst_valid, 1'b0);
        chk("midrst_addr", imem_req_addr, RESET_PC);
        @(negedge clock);
        rst_n = 1'b1;
        cycle();

        // Randomized traffic against the fetch-stream model.
        exp_pc     = RESET_PC;
        mem_busy   = 1'b0;
        mem_addr   = 64'h0;
        mem_cnt    = 0;
        idle_cnt   = 0;
        deliveries = 0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            chk("pc_addr", imem_req_addr, exp_pc);
            if (prev_stall) chk("hold_stable", inst_valid, 1'b1);
            if (inst_valid) begin
                chk("rnd_inst_pc", inst_pc, exp_pc);
                chk("rnd_inst", inst, exp_word(exp_pc));
                chk("rnd_inst_err", inst_err, exp_fault(exp_pc));
                idle_cnt = 0;
            end
            if (imem_req_valid) chk("one_outstanding", mem_busy, 1'b0);
            idle_cnt++;
            if (idle_cnt > 60) begin
                chk("progress_timeout", idle_cnt, 64'd60);
                idle_cnt = 0;
            end

            idle_inputs();
            if (mem_busy && mem_cnt == 0) begin
                respond(mem_word(mem_addr), mem_fault(mem_addr));
            end else if (!mem_busy && $urandom_range(0, 9) == 0) begin
                respond($urandom, 1'($urandom_range(0, 1)));
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                tgt = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
                if ($urandom_range(0, 7) == 0) tgt[1] = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                idle_cnt       = 0;
            end

            fire = imem_req_valid && imem_req_ready;
            prev_stall = inst_valid && !inst_ready && !redirect_valid;
            if (inst_valid && inst_ready) deliveries++;
            if (redirect_valid) exp_pc = redirect_pc;
            else if (inst_valid && inst_ready) exp_pc = exp_pc + 64'd4;
            if (mem_busy) begin
                if (imem_rsp_valid) mem_busy = 1'b0;
                else mem_cnt--;
            end
            if (fire) begin
                mem_busy = 1'b1;
                mem_addr = imem_req_addr;
                mem_cnt  = $urandom_range(0, 3);
            end
            cycle();
        end
        chk("enough_deliveries", (deliveries >= 200), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
